fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch with a one-entry hold buffer, a branch redirect path and an IF/ID register.
// Latency: one cycle from an imem response to IF/ID. Backpressure: stall freezes IF/ID, and a word that arrives during a stall waits in the hold buffer with no request outstanding.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [5:0]  op
);

  typedef enum logic [1:0] {FETCH, HELD, KILL} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } slot_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pend_addr;
  slot_t       hold;
  slot_t       if_id;
  logic        if_id_vld;

  logic [31:0] pc_plus4;
  logic [31:0] target_al;
  logic        unused_tgt_bits;

  assign pc_plus4        = pc + 32'd4;
  assign target_al       = {br_target[31:2], 2'b00};
  assign unused_tgt_bits = ^br_target[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      pend_addr <= RESET_PC;
      hold      <= '0;
      if_id     <= '0;
      if_id_vld <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (br_taken) begin
            if_id     <= '0;
            if_id_vld <= 1'b0;
            hold      <= '0;
            pc        <= target_al;
            // An unanswered request is still in flight at the old address; drain it in KILL.
            if (!imem_ready) begin
              state     <= KILL;
              pend_addr <= pc;
            end
          end else if (imem_ready) begin
            pc <= pc_plus4;
            if (stall) begin
              hold  <= '{instr: imem_rdata, pc4: pc_plus4};
              state <= HELD;
            end else begin
              if_id     <= '{instr: imem_rdata, pc4: pc_plus4};
              if_id_vld <= 1'b1;
            end
          end else if (!stall) begin
            if_id     <= '0;
            if_id_vld <= 1'b0;
          end
        end

        HELD: begin
          if (br_taken) begin
            if_id     <= '0;
            if_id_vld <= 1'b0;
            hold      <= '0;
            pc        <= target_al;
            state     <= FETCH;
          end else if (!stall) begin
            if_id     <= hold;
            if_id_vld <= 1'b1;
            hold      <= '0;
            state     <= FETCH;
          end
        end

        KILL: begin
          // The response to the pre-redirect request is always dropped.
          if (br_taken) begin
            if_id     <= '0;
            if_id_vld <= 1'b0;
            pc        <= target_al;
            if (imem_ready) state <= FETCH;
          end else begin
            if (imem_ready) state <= FETCH;
            if (!stall) begin
              if_id     <= '0;
              if_id_vld <= 1'b0;
            end
          end
        end

        default: state <= FETCH;
      endcase
    end
  end

  assign imem_req    = !rst && (state != HELD);
  assign imem_addr   = (state == KILL) ? pend_addr : pc;
  assign if_id_instr = if_id.instr;
  assign if_id_pc4   = if_id.pc4;
  assign if_id_valid = if_id_vld;
  assign op          = if_id.instr[31:26];

endmodule
